morse_char_buffer: RTL and testbench
====================================

Name: morse_char_buffer

Overview:
- Twelve-slot character store for the Morse-code transmitter.
- Captures the character byte on `datos` into the slot addressed by the character counter `conta_carac` (1..12).
- Presents all twelve stored characters in parallel on `reg1`..`reg12` to the downstream Morse encoder/serializer.
- Sits between the character-entry/counter logic and the encoder.

Parameters:
- DATA_W, 8, width of one character and of every output slot (ASCII byte).
- NUM_SLOTS, 12, number of slots. Fixed by the port list; may not be overridden.
- IDX_W, 4, width of the slot-index input.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- datos  input  DATA_W  character byte to store.
- conta_carac  input  IDX_W  slot index. 1..12 selects reg1..reg12; 0 = idle/no write; 13..15 ignored.
- reg1 .. reg12  output  DATA_W each  stored characters, slot 1 to slot 12, driven directly from flops.

Behaviour:
- All slots are plain registers clocked on CLK rising edge; outputs are never combinational from inputs.
- Reset:
  - RST=1 at a rising edge sets reg1..reg12 to 8'h00.
  - RST has priority over any write in the same cycle.
  - Reset asserted mid-sequence clears all slots, including ones already written.
- Write:
  - When RST=0 and 1 ≤ conta_carac ≤ 12, the slot numbered conta_carac loads datos at the edge.
  - Write latency is 1 cycle: the value is visible on regN right after that edge.
- Exactly one slot is written per cycle; all other slots hold their value.
- conta_carac=0: no write, all slots hold. This is the idle/end-of-message code.
- conta_carac=13..15: no write, all slots hold. No error flag.
- Rewriting the same slot in consecutive cycles: last value wins.
- No handshake. The counter logic must hold conta_carac and datos stable around the sampling edge; the block samples both on the same edge.
- No wrap-around logic inside the block; the index is decoded as-is.

Optional Feature:
- Macro MORSE_CHAR_FILTER_EN.
- Defined: before storage, datos is checked for Morse-encodable ASCII (8'h41..8'h5A 'A'-'Z', 8'h30..8'h39 '0'-'9', 8'h20 space). Any other value is stored as 8'h20 (space). Write/hold rules are unchanged.
- Undefined: datos is stored unmodified.

Decomposition:
- Shared package morse_pkg:
  - constants DATA_W=8, NUM_SLOTS=12, IDX_W=4, CHAR_SPACE=8'h20, RESET_CHAR=8'h00;
  - typedef char_t (logic [DATA_W-1:0]);
  - function is_morse_char(char_t) used by the filter.
- One natural sub-module, char_slot: a single DATA_W register with sync reset and load-enable, instantiated 12 times.
- The top level decodes conta_carac into one-hot enables, applies the optional filter, and wires the slots to reg1..reg12.

Test Plan:
- Reset: hold RST=1 for 8 cycles with datos=8'h40, conta_carac=1 -> reg1..reg12 all 8'h00 (reset beats write).
- Sequential fill: RST=0; for k=1..12 set conta_carac=k, datos=8'h40+5k for one edge each. Filter off: reg1..reg12 = 45,4A,4F,54,59,5E,63,68,6D,72,77,7C (hex). Filter on: 5E,63,68,6D,72,77,7C are stored as 20; 45,4A,4F,54,59 are unchanged.
- Idle hold: after the fill, conta_carac=0, datos=8'h00 for 10 cycles -> all slots unchanged.
- Out-of-range: conta_carac=13,14,15 with datos=8'hFF -> no slot changes.
- Overwrite and mid-operation reset:
  - conta_carac=3, datos=8'h53 -> reg3=8'h53 after 1 cycle, other slots unchanged.
  - Then assert RST for 1 cycle while conta_carac=5 -> all slots 8'h00, reg5 not written.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared constants, character type and Morse-encodable check for the character buffer.
// The check is only used when MORSE_CHAR_FILTER_EN is defined.
package morse_pkg;

   localparam int DATA_W    = 8;
   localparam int NUM_SLOTS = 12;
   localparam int IDX_W     = 4;

   localparam logic [DATA_W-1:0] CHAR_SPACE = 8'h20;
   localparam logic [DATA_W-1:0] RESET_CHAR = 8'h00;

   typedef logic [DATA_W-1:0] char_t;

   // Upper-case letters, digits and space are the only characters the encoder can send.
   function automatic logic is_morse_char(input char_t c);
      return ((c >= 8'h41) && (c <= 8'h5A)) ||
             ((c >= 8'h30) && (c <= 8'h39)) ||
             (c == CHAR_SPACE);
   endfunction

endpackage

// File: rtl/morse_char_buffer_char_slot.sv
// One character slot of the Morse buffer: a DATA_W register with
// synchronous reset (priority) and load enable.
module char_slot
   import morse_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  char_t d,
   output char_t q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_CHAR;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/morse_char_buffer.sv
// Twelve-slot character store feeding the Morse encoder; conta_carac 1..12 selects the slot.
// Define MORSE_CHAR_FILTER_EN to replace non-encodable characters with a space before storage.
module morse_char_buffer
   import morse_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] datos,
   input  logic [IDX_W-1:0]  conta_carac,
   output logic [DATA_W-1:0] reg1,
   output logic [DATA_W-1:0] reg2,
   output logic [DATA_W-1:0] reg3,
   output logic [DATA_W-1:0] reg4,
   output logic [DATA_W-1:0] reg5,
   output logic [DATA_W-1:0] reg6,
   output logic [DATA_W-1:0] reg7,
   output logic [DATA_W-1:0] reg8,
   output logic [DATA_W-1:0] reg9,
   output logic [DATA_W-1:0] reg10,
   output logic [DATA_W-1:0] reg11,
   output logic [DATA_W-1:0] reg12
);

   logic [NUM_SLOTS-1:0] slot_en;
   char_t                store_char;
   char_t                slot_q [NUM_SLOTS];

   // Index 0 (idle) and 13..15 match no slot, so nothing is written for them.
   always_comb begin
      slot_en = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (conta_carac == IDX_W'(i + 1)) begin
            slot_en[i] = 1'b1;
         end
      end
   end

`ifdef MORSE_CHAR_FILTER_EN
   always_comb begin
      store_char = is_morse_char(datos) ? datos : CHAR_SPACE;
   end
`else
   always_comb begin
      store_char = datos;
   end
`endif

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      char_slot u_slot (
         .clk  (CLK),
         .rst  (RST),
         .load (slot_en[g]),
         .d    (store_char),
         .q    (slot_q[g])
      );
   end

   assign reg1  = slot_q[0];
   assign reg2  = slot_q[1];
   assign reg3  = slot_q[2];
   assign reg4  = slot_q[3];
   assign reg5  = slot_q[4];
   assign reg6  = slot_q[5];
   assign reg7  = slot_q[6];
   assign reg8  = slot_q[7];
   assign reg9  = slot_q[8];
   assign reg10 = slot_q[9];
   assign reg11 = slot_q[10];
   assign reg12 = slot_q[11];

endmodule

// File: tb/tb_morse_char_buffer.sv
// Scoreboard bench for morse_char_buffer: stimulus pushes the expected twelve-slot
// snapshot after each edge, a negedge monitor pops and compares it.
module tb_morse_char_buffer;

   typedef logic [11:0][7:0] snap_t;

   logic       CLK;
   logic       RST;
   logic [7:0] datos;
   logic [3:0] conta_carac;
   logic [7:0] reg1, reg2, reg3, reg4, reg5, reg6;
   logic [7:0] reg7, reg8, reg9, reg10, reg11, reg12;

   snap_t dut_snap;
   snap_t model;
   snap_t exp_q [$];
   int    checks;
   int    errors;

   morse_char_buffer dut (
      .CLK         (CLK),
      .RST         (RST),
      .datos       (datos),
      .conta_carac (conta_carac),
      .reg1        (reg1),
      .reg2        (reg2),
      .reg3        (reg3),
      .reg4        (reg4),
      .reg5        (reg5),
      .reg6        (reg6),
      .reg7        (reg7),
      .reg8        (reg8),
      .reg9        (reg9),
      .reg10       (reg10),
      .reg11       (reg11),
      .reg12       (reg12)
   );

   assign dut_snap = {reg12, reg11, reg10, reg9, reg8, reg7,
                      reg6, reg5, reg4, reg3, reg2, reg1};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Hand-computed stored value for the sequential fill, datos = 8'h40 + 5k.
   function automatic logic [7:0] fillExpect(input int k);
      logic [7:0] raw;
      case (k)
         1: raw = 8'h45;  2: raw = 8'h4A;  3: raw = 8'h4F;  4: raw = 8'h54;
         5: raw = 8'h59;  6: raw = 8'h5E;  7: raw = 8'h63;  8: raw = 8'h68;
         9: raw = 8'h6D; 10: raw = 8'h72; 11: raw = 8'h77; 12: raw = 8'h7C;
         default: raw = 8'hXX;
      endcase
`ifdef MORSE_CHAR_FILTER_EN
      if (k >= 6) raw = 8'h20;
`endif
      return raw;
   endfunction

   // One clock of stimulus; the expected snapshot after the edge is queued for the monitor.
   task automatic applyStimulus(input logic rst_in, input logic [3:0] idx,
                                input logic [7:0] data, input logic [7:0] stored);
      @(negedge CLK);
      RST         = rst_in;
      conta_carac = idx;
      datos       = data;
      @(posedge CLK);
      if (rst_in) begin
         model = '0;
      end else if (idx >= 4'd1 && idx <= 4'd12) begin
         model[idx - 4'd1] = stored;
      end
      exp_q.push_back(model);
   endtask

   task automatic checkOutput(input snap_t want);
      for (int s = 0; s < 12; s++) begin
         checks++;
         if (dut_snap[s] !== want[s]) begin
            errors++;
            $display("[TB] FAIL reg%0d got=%h want=%h", s + 1, dut_snap[s], want[s]);
         end
      end
   endtask

   // Monitor: outputs are always valid, so every queued snapshot is compared on the next negedge.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      int budget;
      checks      = 0;
      errors      = 0;
      model       = '0;
      RST         = 1'b1;
      datos       = 8'h40;
      conta_carac = 4'd1;

      $display("[TB] reset with write request pending");
      for (int c = 0; c < 8; c++) applyStimulus(1'b1, 4'd1, 8'h40, 8'h40);

      $display("[TB] sequential fill");
      for (int k = 1; k <= 12; k++)
         applyStimulus(1'b0, 4'(k), 8'(8'h40 + 5 * k), fillExpect(k));

      $display("[TB] idle hold");
      for (int c = 0; c < 10; c++) applyStimulus(1'b0, 4'd0, 8'h00, 8'h00);

      $display("[TB] out-of-range indices");
      for (int k = 13; k <= 15; k++) applyStimulus(1'b0, 4'(k), 8'hFF, 8'hFF);

      $display("[TB] overwrite slot 3, back-to-back rewrite of slot 7");
      applyStimulus(1'b0, 4'd3, 8'h53, 8'h53);
      applyStimulus(1'b0, 4'd7, 8'h31, 8'h31);
      applyStimulus(1'b0, 4'd7, 8'h39, 8'h39);
      applyStimulus(1'b0, 4'd0, 8'h00, 8'h00);

      $display("[TB] mid-operation reset with slot 5 selected");
      applyStimulus(1'b1, 4'd5, 8'h41, 8'h41);
      applyStimulus(1'b0, 4'd0, 8'h41, 8'h41);

      $display("[TB] write after reset");
      applyStimulus(1'b0, 4'd12, 8'h5A, 8'h5A);
      applyStimulus(1'b0, 4'd1, 8'h20, 8'h20);

      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
         @(posedge CLK);
         budget++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain got=%0d pending want=0 pending", exp_q.size());
      end
      @(posedge CLK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
